// File: rtl/edid_hpd_ctrl_if.sv
// Signal bundle between edid_hpd_ctrl and its surroundings: host update stream,
// I2C slave byte reads, the single-port EDID RAM and the HPD/status outputs.
interface edid_hpd_ctrl_if;
  // Host update stream
  logic       upd_start;
  logic       upd_valid;
  logic [7:0] upd_data;
  logic       upd_ready;
  // I2C slave byte reads
  logic       i2c_rd_req;
  logic [7:0] i2c_rd_addr;
  logic [7:0] i2c_rd_data;
  logic       i2c_rd_ack;
  // EDID RAM port
  logic [7:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  // Connector and status
  logic       hpd;
  logic       busy;
  logic       csum_err;

  // Controller side
  modport slave (
    input  upd_start, upd_valid, upd_data, i2c_rd_req, i2c_rd_addr, ram_rdata,
    output upd_ready, i2c_rd_data, i2c_rd_ack, ram_addr, ram_we, ram_wdata, hpd, busy,
           csum_err
  );

  // Environment side: host, I2C slave and RAM
  modport master (
    output upd_start, upd_valid, upd_data, i2c_rd_req, i2c_rd_addr, ram_rdata,
    input  upd_ready, i2c_rd_data, i2c_rd_ack, ram_addr, ram_we, ram_wdata, hpd, busy,
           csum_err
  );
endinterface

// File: rtl/edid_hpd_ctrl.sv
// EDID storage sequencer and hot-plug-detect owner. Shares one 256x8 synchronous RAM
// between host image reloads and I2C byte reads, and holds HPD low for a minimum time
// around every reload, raising it again only when the image checksum is zero.
module edid_hpd_ctrl #(
  parameter int unsigned EDID_BYTES     = 128,
  parameter int unsigned HPD_LOW_CYCLES = 5000000
) (
  input  logic           clk,
  input  logic           rst,
  edid_hpd_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(HPD_LOW_CYCLES);
  localparam logic [CntW-1:0] LowMax   = CntW'(HPD_LOW_CYCLES - 1);
  localparam logic [7:0]      LastAddr = 8'(EDID_BYTES - 1);

  localparam logic [2:0] StHpdLow  = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StCheck   = 3'd2;
  localparam logic [2:0] StOnline  = 3'd3;
  localparam logic [2:0] StOffline = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] low_cnt_q, low_cnt_d;
  logic            hpd_q, hpd_d;
  logic            csum_err_q, csum_err_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      sum_q, sum_d;

  // Read pipeline: request issued -> RAM data valid -> ack
  logic            rd_pend_q;
  logic            rd_real_q;
  logic            ack_q;
  logic [7:0]      rd_data_q;

  logic            xfer;
  logic            rd_issue;
  logic            rd_real;
  logic            csum_bad;
  logic            low_done;
  logic [7:0]      ram_addr;
  logic            ram_we;
  logic [7:0]      ram_wdata;

  // upd_start wins over a byte offered in the same cycle; that byte is dropped.
  assign xfer     = (state_q == StLoad) && bus.upd_valid && !bus.upd_start;
  // Only one read in flight: a new request is taken once the previous ack has gone.
  assign rd_issue = !rst && bus.i2c_rd_req && !rd_pend_q && !ack_q;
  // While loading, the RAM belongs to the host and reads are answered with 8'hFF.
  assign rd_real  = rd_issue && !xfer &&
                    ((state_q == StHpdLow) || (state_q == StOnline) || (state_q == StOffline));
  assign csum_bad = (sum_q != 8'h00);
  assign low_done = (low_cnt_q == LowMax);

  // Next-state logic for the load/HPD sequencer.
  always_comb begin
    state_d    = state_q;
    // Saturating counter; once the minimum low time has elapsed it stays there.
    low_cnt_d  = low_done ? low_cnt_q : low_cnt_q + CntW'(1);
    hpd_d      = hpd_q;
    csum_err_d = csum_err_q;
    wr_addr_d  = wr_addr_q;
    sum_d      = sum_q;

    case (state_q)
      StHpdLow: begin
        if (low_done) begin
          state_d = csum_err_q ? StOffline : StOnline;
          hpd_d   = !csum_err_q;
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_addr_d = wr_addr_q + 8'd1;
          sum_d     = sum_q + bus.upd_data;
          if (wr_addr_q == LastAddr) begin
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        csum_err_d = csum_bad;
        if (low_done) begin
          state_d = csum_bad ? StOffline : StOnline;
          hpd_d   = !csum_bad;
        end else begin
          state_d = StHpdLow;
        end
      end
      StOnline, StOffline: begin
      end
      default: begin
        state_d = StHpdLow;
        hpd_d   = 1'b0;
      end
    endcase

    // A reload restarts the low period only if HPD was up, so it never shortens one.
    if (bus.upd_start) begin
      state_d    = StLoad;
      hpd_d      = 1'b0;
      csum_err_d = 1'b0;
      wr_addr_d  = 8'h00;
      sum_d      = 8'h00;
      if (hpd_q) begin
        low_cnt_d = '0;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHpdLow;
      low_cnt_q  <= '0;
      hpd_q      <= 1'b0;
      csum_err_q <= 1'b0;
      wr_addr_q  <= 8'h00;
      sum_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      low_cnt_q  <= low_cnt_d;
      hpd_q      <= hpd_d;
      csum_err_q <= csum_err_d;
      wr_addr_q  <= wr_addr_d;
      sum_q      <= sum_d;
    end
  end

  // Read pipeline: capture RAM data (or the 8'hFF filler) one cycle after issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      rd_real_q <= 1'b0;
      ack_q     <= 1'b0;
      rd_data_q <= 8'hFF;
    end else begin
      rd_pend_q <= rd_issue;
      rd_real_q <= rd_real;
      ack_q     <= rd_pend_q;
      if (rd_pend_q) begin
        rd_data_q <= rd_real_q ? bus.ram_rdata : 8'hFF;
      end
    end
  end

  // RAM port mux: host writes first, then real I2C reads, otherwise parked at 0.
  always_comb begin
    ram_addr  = 8'h00;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (xfer) begin
      ram_we    = 1'b1;
      ram_addr  = wr_addr_q;
      ram_wdata = bus.upd_data;
    end else if (rd_real) begin
      ram_addr  = bus.i2c_rd_addr;
    end
  end

  assign bus.ram_addr    = ram_addr;
  assign bus.ram_we      = ram_we;
  assign bus.ram_wdata   = ram_wdata;
  assign bus.upd_ready   = (state_q == StLoad);
  assign bus.i2c_rd_data = rd_data_q;
  assign bus.i2c_rd_ack  = ack_q;
  assign bus.hpd         = hpd_q;
  assign bus.busy        = (state_q != StOnline) && (state_q != StOffline);
  assign bus.csum_err    = csum_err_q;

endmodule

// File: tb/tb_edid_hpd_ctrl.sv
// Bench for edid_hpd_ctrl: directed reload/read scenarios, a timestamp-based model
// checked every cycle, and literal expectations pinning the key timings and data.
module tb_edid_hpd_ctrl;
  localparam int EB  = 4;
  localparam int LOW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edid_hpd_ctrl_if bus_if ();

  edid_hpd_ctrl #(
    .EDID_BYTES    (EB),
    .HPD_LOW_CYCLES(LOW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // Synchronous RAM with one cycle read latency
  logic [7:0] ram     [256];
  logic [7:0] exp_mem [256];
  always @(posedge clk) begin
    if (bus_if.ram_we) ram[bus_if.ram_addr] <= bus_if.ram_wdata;
    bus_if.ram_rdata <= ram[bus_if.ram_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: phases 0=waiting low, 1=loading, 2=checksum cycle, 3=up (online/offline).
  // HPD comes up at max(check+1, drop+LOW); reads answer 2 cycles after issue.
  int         cyc, phase, drop, up_cyc, nbytes, ack_cyc, next_rd;
  logic       m_err;
  logic [7:0] m_sum, pend_data, last_data;

  initial begin
    logic exp_hpd, xfer, issue, real_rd;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; phase = 0; drop = 0; up_cyc = LOW; nbytes = 0; m_sum = 8'h00;
        m_err = 1'b0; ack_cyc = -1; next_rd = 0; last_data = 8'hFF; pend_data = 8'hFF;
      end else begin
        if (phase == 0 && cyc >= up_cyc) phase = 3;
        if (cyc == ack_cyc) last_data = pend_data;
        exp_hpd = (phase == 3) && !m_err;
        xfer    = (phase == 1) && bus_if.upd_valid && !bus_if.upd_start;
        issue   = bus_if.i2c_rd_req && (cyc >= next_rd);
        real_rd = issue && (phase == 0 || phase == 3);

        chk("hpd", bus_if.hpd, exp_hpd);
        chk("busy", bus_if.busy, phase != 3);
        chk("upd_ready", bus_if.upd_ready, phase == 1);
        chk("csum_err", bus_if.csum_err, m_err);
        chk("ram_we", bus_if.ram_we, xfer);
        chk("rd_ack", bus_if.i2c_rd_ack, cyc == ack_cyc);
        chk("rd_data", bus_if.i2c_rd_data, last_data);
        if (xfer) begin
          chk("ram_addr_wr", bus_if.ram_addr, nbytes);
          chk("ram_wdata", bus_if.ram_wdata, bus_if.upd_data);
        end
        if (real_rd) chk("ram_addr_rd", bus_if.ram_addr, bus_if.i2c_rd_addr);
        if ((phase == 1 || phase == 2) && !xfer && bus_if.i2c_rd_req)
          chk("addr_not_rd", bus_if.ram_addr == bus_if.i2c_rd_addr, 0);

        if (phase == 2) begin
          m_err  = (m_sum != 8'h00);
          up_cyc = (cyc + 1 > drop + LOW) ? cyc + 1 : drop + LOW;
          phase  = 0;
        end
        if (issue) begin
          ack_cyc   = cyc + 2;
          next_rd   = cyc + 3;
          pend_data = real_rd ? exp_mem[bus_if.i2c_rd_addr] : 8'hFF;
        end
        if (xfer) begin
          exp_mem[nbytes[7:0]] = bus_if.upd_data;
          m_sum  = m_sum + bus_if.upd_data;
          nbytes = nbytes + 1;
          if (nbytes == EB) phase = 2;
        end
        if (bus_if.upd_start) begin
          if (exp_hpd) drop = cyc + 1;
          phase = 1; nbytes = 0; m_sum = 8'h00; m_err = 1'b0;
        end
        cyc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with hpd low, starting from 'pre' already elapsed.
  task automatic count_low(input int pre, output int n);
    n = pre;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_if.hpd) break;
      n++;
    end
  endtask

  task automatic load4(input logic [31:0] bytes);
    bus_if.upd_start = 1'b1;
    tick();
    bus_if.upd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_if.upd_valid = 1'b1;
      bus_if.upd_data  = bytes[31-8*i -: 8];
      tick();
    end
    bus_if.upd_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d, output int lat);
    bus_if.i2c_rd_req  = 1'b1;
    bus_if.i2c_rd_addr = a;
    d   = 8'h00;
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_if.i2c_rd_ack) begin
        d = bus_if.i2c_rd_data;
        break;
      end
      lat++;
    end
    @(posedge clk);
    #1;
    bus_if.i2c_rd_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hpd"}, bus_if.hpd, 0);
    chk({tag, "_upd_ready"}, bus_if.upd_ready, 0);
    chk({tag, "_ack"}, bus_if.i2c_rd_ack, 0);
    chk({tag, "_rd_data"}, bus_if.i2c_rd_data, 8'hFF);
    chk({tag, "_ram_we"}, bus_if.ram_we, 0);
    chk({tag, "_ram_addr"}, bus_if.ram_addr, 8'h00);
    chk({tag, "_ram_wdata"}, bus_if.ram_wdata, 8'h00);
    chk({tag, "_csum_err"}, bus_if.csum_err, 0);
    chk({tag, "_busy"}, bus_if.busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    logic [7:0] d;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 3 + 1);
      exp_mem[i] = 8'(i * 3 + 1);
    end
    ram[5]     = 8'h3C;
    exp_mem[5] = 8'h3C;
    bus_if.upd_start   = 1'b0;
    bus_if.upd_valid   = 1'b0;
    bus_if.upd_data    = 8'h00;
    bus_if.i2c_rd_req  = 1'b0;
    bus_if.i2c_rd_addr = 8'h00;

    // Power-on reset, then HPD low for exactly LOW cycles
    repeat (3) tick();
    chk_reset("por");
    rst = 1'b0;
    count_low(0, n);
    chk("por_low_len", n, 16);
    chk("por_busy_at_rise", bus_if.busy, 0);

    // Online read of preloaded byte
    tick();
    rd(8'd5, d, lat);
    chk("rd5_data", d, 8'h3C);
    chk("rd5_lat", lat, 2);
    repeat (4) tick();

    // Good image: HPD drops and returns LOW cycles later
    load4(32'h102030A0);
    count_low(4, n);
    chk("good_low_len", n, 16);
    chk("good_csum_err", bus_if.csum_err, 0);
    tick();
    rd(8'd2, d, lat);
    chk("good_rd2", d, 8'h30);

    // Bad checksum: ends OFFLINE, reads still served from RAM
    tick();
    load4(32'h102030A1);
    repeat (30) tick();
    chk("bad_hpd", bus_if.hpd, 0);
    chk("bad_csum_err", bus_if.csum_err, 1);
    chk("bad_busy", bus_if.busy, 0);
    rd(8'd1, d, lat);
    chk("bad_rd1", d, 8'h20);

    // Read during LOAD returns 8'hFF with the usual latency
    tick();
    bus_if.upd_start = 1'b1;
    tick();
    bus_if.upd_start = 1'b0;
    bus_if.upd_valid = 1'b1; bus_if.upd_data = 8'h10;
    bus_if.i2c_rd_req = 1'b1; bus_if.i2c_rd_addr = 8'd5;
    tick();
    bus_if.upd_data = 8'h20;
    tick();
    bus_if.upd_data = 8'h30;
    @(negedge clk);
    chk("ld_ack", bus_if.i2c_rd_ack, 1);
    chk("ld_rd_data", bus_if.i2c_rd_data, 8'hFF);
    @(posedge clk);
    #1;
    bus_if.i2c_rd_req = 1'b0; bus_if.upd_data = 8'hA0;
    tick();
    bus_if.upd_valid = 1'b0;
    count_low(0, n);
    chk("ld_hpd_up", bus_if.hpd, 1);

    // Restart mid-load with a byte offered in the restart cycle
    tick();
    bus_if.upd_start = 1'b1;
    tick();
    bus_if.upd_start = 1'b0;
    bus_if.upd_valid = 1'b1; bus_if.upd_data = 8'h10;
    tick();
    bus_if.upd_data = 8'h20;
    tick();
    bus_if.upd_start = 1'b1; bus_if.upd_data = 8'h55;
    tick();
    bus_if.upd_start = 1'b0; bus_if.upd_data = 8'h11;
    tick();
    bus_if.upd_data = 8'h22;
    tick();
    bus_if.upd_data = 8'h33;
    tick();
    bus_if.upd_data = 8'h9A;
    tick();
    bus_if.upd_valid = 1'b0;
    count_low(7, n);
    chk("restart_low_len", n, 16);
    tick();
    rd(8'd0, d, lat);
    chk("restart_rd0", d, 8'h11);
    rd(8'd2, d, lat);
    chk("restart_rd2", d, 8'h33);

    // Reset asserted mid-load
    tick();
    bus_if.upd_start = 1'b1;
    tick();
    bus_if.upd_start = 1'b0;
    bus_if.upd_valid = 1'b1; bus_if.upd_data = 8'h10;
    tick();
    bus_if.upd_data = 8'h20;
    tick();
    bus_if.upd_data = 8'h30;
    rst = 1'b1;
    #1;
    chk_reset("midload");
    bus_if.upd_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    count_low(0, n);
    chk("midload_low_len", n, 16);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/edid_hpd_ctrl.md
Name: edid_hpd_ctrl

Overview:
- Sequences the EDID storage behind the HDMI-in DDC slave and owns the hot-plug-detect (HPD) line.
- Arbitrates one single-port 256x8 synchronous EDID RAM between two requesters: the I2C slave's byte reads and a host update stream that reloads the EDID image.
- Drops HPD for a guaranteed minimum time around every (re)load and re-asserts it only if the loaded image's checksum is valid.

Parameters:
- EDID_BYTES, 128, bytes accepted per update (1..256); RAM addresses 0..EDID_BYTES-1 are written.
- HPD_LOW_CYCLES, 5000000, minimum clk cycles HPD is held low per drop (100 ms at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- upd_start  in  1  single-cycle pulse: begin loading a new EDID image.
- upd_valid  in  1  update byte valid.
- upd_data  in  8  update byte.
- upd_ready  out  1  controller accepts a byte this cycle.
- i2c_rd_req  in  1  I2C slave requests a byte.
- i2c_rd_addr  in  8  requested byte address, stable while i2c_rd_req is high.
- i2c_rd_data  out  8  returned byte; held until the next ack.
- i2c_rd_ack  out  1  one-cycle pulse: i2c_rd_data is valid.
- ram_addr  out  8  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data; 1-cycle registered latency.
- hpd  out  1  hot-plug-detect drive to the HDMI connector.
- busy  out  1  high in every state except ONLINE and OFFLINE.
- csum_err  out  1  last load failed its checksum; sticky until the next upd_start.

Behaviour:
- Reset values:
  - hpd=0, upd_ready=0, i2c_rd_ack=0, i2c_rd_data=8'hFF, ram_we=0, ram_addr=0, ram_wdata=0, csum_err=0, busy=1.
  - state=HPD_LOW; low counter=0. The RAM keeps its preloaded image.
- HPD_LOW:
  - hpd=0; the low counter increments each cycle.
  - When it reaches HPD_LOW_CYCLES-1: go to ONLINE if csum_err=0, else OFFLINE.
- ONLINE: hpd=1; serves reads. OFFLINE: hpd=0; serves reads.
- upd_start in any state:
  - hpd<=0, csum_err<=0, write address<=0, running sum<=0, state<=LOAD.
  - The low counter restarts at 0 only if hpd was 1 in that cycle; otherwise it keeps counting, so a restart never shortens a low period.
  - upd_start has priority over a same-cycle byte transfer; that byte is dropped.
- LOAD:
  - upd_ready=1, hpd=0; the low counter keeps counting.
  - Transfer occurs when upd_valid and upd_ready are both high. In the same cycle: ram_we=1, ram_addr=write address, ram_wdata=upd_data, sum<=sum+upd_data (mod 256), address++.
  - After byte EDID_BYTES-1: state<=CHECK, upd_ready<=0.
- CHECK (1 cycle):
  - csum_err<=(sum!=0).
  - Then go to HPD_LOW to finish the remaining low time. If the low count already reached HPD_LOW_CYCLES-1, go directly to ONLINE/OFFLINE.
- Read arbitration (one outstanding read at a time):
  - i2c_rd_req is sampled only when no read is pending.
  - In ONLINE, OFFLINE or HPD_LOW with no write this cycle: ram_addr<=i2c_rd_addr at cycle T. ram_rdata is captured into i2c_rd_data at T+2, with i2c_rd_ack=1 at T+2.
  - In LOAD or CHECK: the RAM is not read; i2c_rd_data<=8'hFF with i2c_rd_ack at T+2 (same latency).
  - A req still high after its ack starts a new read the following cycle; the requester deasserts on ack.
  - The host write path has priority over I2C reads for the RAM port.
- Reset mid-load: immediate return to HPD_LOW with hpd=0. The partially written RAM is not restored; the bench checks only state and outputs.

Test Plan:
(Overrides: HPD_LOW_CYCLES=16, EDID_BYTES=4.)
- Release reset -> hpd=0 for exactly 16 cycles, then hpd=1; busy falls in the same cycle hpd rises.
- In ONLINE, preloaded RAM[5]=8'h3C, req addr 5 at T -> ram_addr=5 at T, i2c_rd_ack pulse at T+2 with i2c_rd_data=8'h3C; no second ack while req is low.
- upd_start, then bytes 8'h10, 8'h20, 8'h30, 8'hA0 (sum=0) -> hpd falls the next cycle; ram_we on four transfer cycles at addresses 0..3; csum_err=0; hpd rises 16 cycles after it fell.
- Same sequence with last byte 8'hA1 -> csum_err=1, hpd stays 0 (OFFLINE); reads still return RAM data.
- Read request during LOAD -> i2c_rd_ack after 2 cycles with 8'hFF; ram_we is never blocked; ram_addr is never driven from i2c_rd_addr.
- upd_start after the 2nd byte, with upd_valid high in the same cycle -> that byte is not written; address restarts at 0; total hpd-low time is still >= 16 cycles from the original drop; asserting rst mid-LOAD returns all outputs to their reset values immediately.
